// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, bus widths and colour field positions for the
// scan generator and its pixel-tick divider.
package vga_pkg;
  localparam int COORD_W = 10;
  localparam int RGB_W   = 12;

  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int DEF_H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  // rgb_in layout is {R, G, B}, four bits each
  localparam int R_HI = 11;
  localparam int R_LO = 8;
  localparam int G_HI = 7;
  localparam int G_LO = 4;
  localparam int B_HI = 3;
  localparam int B_LO = 0;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video;
  } stage1_t;

  localparam stage1_t STAGE1_RST = '{hsync: 1'b1, vsync: 1'b1, video: 1'b0};
endpackage

// File: rtl/vga_pixel_tick.sv
// Pixel-rate enable: one clk wide pulse every CLK_DIV system clocks.
module vga_pixel_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_tick
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign pix_tick = (div_cnt == DIV_LAST);
endmodule

// File: rtl/vga_scan_gen.sv
// VGA scan generator: h/v counters, map-window coordinates for the renderer,
// and a one-tick output stage that aligns blanked colour with the syncs.
module vga_scan_gen
  import vga_pkg::*;
#(
  parameter int H_DISPLAY    = DEF_H_DISPLAY,
  parameter int H_FRONT      = DEF_H_FRONT,
  parameter int H_SYNC       = DEF_H_SYNC,
  parameter int H_BACK       = DEF_H_BACK,
  parameter int V_DISPLAY    = DEF_V_DISPLAY,
  parameter int V_FRONT      = DEF_V_FRONT,
  parameter int V_SYNC       = DEF_V_SYNC,
  parameter int V_BACK       = DEF_V_BACK,
  parameter int CLK_DIV      = 4,
  parameter int MAP_ORIGIN_X = 270,
  parameter int MAP_ORIGIN_Y = 190,
  parameter int MAP_WIDTH_X  = 100,
  parameter int MAP_WIDTH_Y  = 100
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               pix_tick,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               video_on,
  output logic [COORD_W-1:0] map_x,
  output logic [COORD_W-1:0] map_y,
  output logic               map_on,
  input  logic [RGB_W-1:0]   rgb_in,
  output logic               vga_hsync,
  output logic               vga_vsync,
  output logic [3:0]         vga_r,
  output logic [3:0]         vga_g,
  output logic [3:0]         vga_b,
  output logic               frame_start
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_DISPLAY);
  localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_DISPLAY);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_DISPLAY + H_FRONT);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_DISPLAY + V_FRONT);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic [COORD_W-1:0] MX_LO    = COORD_W'(MAP_ORIGIN_X);
  localparam logic [COORD_W-1:0] MX_HI    = COORD_W'(MAP_ORIGIN_X + MAP_WIDTH_X);
  localparam logic [COORD_W-1:0] MY_LO    = COORD_W'(MAP_ORIGIN_Y);
  localparam logic [COORD_W-1:0] MY_HI    = COORD_W'(MAP_ORIGIN_Y + MAP_WIDTH_Y);

  logic [COORD_W-1:0] h_cnt;
  logic [COORD_W-1:0] v_cnt;
  logic               h_wrap;
  logic               v_wrap;
  logic               hs_raw;
  logic               vs_raw;
  stage1_t            s1;
  logic [RGB_W-1:0]   rgb_q;

  vga_pixel_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .pix_tick (pix_tick)
  );

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_tick) begin
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Renderer interface: no handshake. map_x/map_y/map_on change right after
  // each tick edge; rgb_in is sampled on the next tick edge only.
  always_comb begin
    video_on = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    map_on   = video_on && (h_cnt >= MX_LO) && (h_cnt < MX_HI)
                        && (v_cnt >= MY_LO) && (v_cnt < MY_HI);
    map_x    = '0;
    map_y    = '0;
    if (map_on) begin
      map_x = h_cnt - MX_LO;
      map_y = v_cnt - MY_LO;
    end
    hs_raw = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    vs_raw = !((v_cnt >= VS_START) && (v_cnt < VS_END));
  end

  assign pix_x = h_cnt;
  assign pix_y = v_cnt;

  // The video bit travels with the syncs so blanking lines up with rgb_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1          <= STAGE1_RST;
      rgb_q       <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_tick && h_wrap && v_wrap;
      if (pix_tick) begin
        s1    <= '{hsync: hs_raw, vsync: vs_raw, video: video_on};
        rgb_q <= rgb_in;
      end
    end
  end

  assign vga_hsync = s1.hsync;
  assign vga_vsync = s1.vsync;
  assign vga_r     = s1.video ? rgb_q[R_HI:R_LO] : 4'h0;
  assign vga_g     = s1.video ? rgb_q[G_HI:G_LO] : 4'h0;
  assign vga_b     = s1.video ? rgb_q[B_HI:B_LO] : 4'h0;
endmodule
